// File: rtl/vga_fb_fetch_arb.sv
// vga_fb_fetch_arb: shares the single-port CPU data RAM between the CPU and a
// once-per-frame fetch of the two VGA display words. The CPU has priority.
// Each VGA read is forced after MAX_WAIT denied cycles, so a fetch always finishes.
// Both display words are committed on the same edge, so a frame never shows
// one old word next to one new word.
//
// Port handshake: a CPU access is taken in any cycle where cpu_req=1 and
// cpu_stall=0. While cpu_stall=1, the CPU holds cpu_we/cpu_addr/cpu_wdata
// stable. Read data returns on cpu_rdata one cycle after the access is taken.
module vga_fb_fetch_arb #(
    parameter logic [31:0] FB_ADDR  = 32'h0000_1000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ram_data_1,
    output logic [31:0] ram_data_2,
    output logic        fetch_busy,
    output logic        frame_miss
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD1    = 3'd1,
        CAP1   = 3'd2,
        RD2    = 3'd3,
        CAP2   = 3'd4,
        COMMIT = 3'd5
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] shadow1;
    logic [31:0] shadow2;
    logic        in_rd;
    logic        vga_gnt;
    logic [31:0] vga_addr;

    // The VGA read wins a read slot when the CPU is quiet or has starved it long enough.
    assign in_rd    = (state == RD1) || (state == RD2);
    assign vga_gnt  = in_rd && (!cpu_req || (wait_cnt == MAX_WAIT_C));
    assign vga_addr = (state == RD2) ? (FB_ADDR + 32'd4) : FB_ADDR;

    // The RAM returns data straight to the CPU; the CPU read latency is never changed.
    assign cpu_rdata  = mem_rdata;
    assign fetch_busy = (state != IDLE);

    // Combinational RAM port mux: the CPU owns the port unless the VGA read is granted.
    always_comb begin
        mem_en    = cpu_req;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (vga_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = vga_addr;
            mem_wdata = '0;
            cpu_stall = cpu_req;
        end
    end

    // Fetch FSM with registered shadow capture, atomic commit, and the miss pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            shadow1    <= '0;
            shadow2    <= '0;
            ram_data_1 <= '0;
            ram_data_2 <= '0;
            frame_miss <= 1'b0;
        end else begin
            frame_miss <= frame_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= RD1;
                        wait_cnt <= '0;
                    end
                end
                RD1: begin
                    if (vga_gnt) begin
                        state <= CAP1;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CAP1: begin
                    shadow1  <= mem_rdata;
                    state    <= RD2;
                    wait_cnt <= '0;
                end
                RD2: begin
                    if (vga_gnt) begin
                        state <= CAP2;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CAP2: begin
                    shadow2 <= mem_rdata;
                    state   <= COMMIT;
                end
                COMMIT: begin
                    ram_data_1 <= shadow1;
                    ram_data_2 <= shadow2;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_fb_fetch_arb.sv
// Bench for vga_fb_fetch_arb: a RAM model drives mem_rdata. A queue-based
// reference model of the fetch predicts every output each cycle. Table vectors,
// hand-written corner sequences and random traffic run against that model.
module tb_vga_fb_fetch_arb;

    localparam logic [31:0] FB_ADDR  = 32'h0000_1000;
    localparam int          MAX_WAIT = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] ram_data_1;
    logic [31:0] ram_data_2;
    logic        fetch_busy;
    logic        frame_miss;

    vga_fb_fetch_arb #(.FB_ADDR(FB_ADDR), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .ram_data_1(ram_data_1), .ram_data_2(ram_data_2),
        .fetch_busy(fetch_busy), .frame_miss(frame_miss)
    );

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'h0101_0107) ^ 32'h5A5A_0000;
    endfunction

    // ---------------- RAM model (environment) ----------------
    logic        poke_en = 1'b0;
    logic [10:0] poke_idx = '0;
    logic [31:0] poke_val = '0;
    logic [31:0] ram [2048];
    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = init_val(i);
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (poke_en) ram[poke_idx] = poke_val;
            if (mem_en) begin
                if (mem_we) ram[mem_addr[12:2]] = mem_wdata;
                else        mem_rdata <= ram[mem_addr[12:2]];
            end
        end
    end

    // ---------------- scoreboard / reference model ----------------
    int n_tests = 0;
    int n_fail  = 0;

    localparam int A_RD0 = 0, A_RD1 = 1, A_GAP = 2, A_COMMIT = 3, A_NONE = 4;
    int          fq[$];          // remaining fetch actions, front = this cycle
    logic [31:0] exp_q[$];       // CPU read data expected next cycle
    logic [31:0] gold [2048];
    logic [31:0] snap [2];
    logic [31:0] m_rd1 = '0, m_rd2 = '0;
    logic        m_miss = 1'b0;
    logic        m_stall = 1'b0;
    logic        rd_pend = 1'b0;
    int          denied = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called once per cycle, mid-cycle, with this cycle's inputs applied.
    task automatic model_step();
        int act;
        int was_len;
        logic gnt;
        check("fetch_busy", fetch_busy, fq.size() != 0);
        check("frame_miss", frame_miss, m_miss);
        check("ram_data_1", ram_data_1, m_rd1);
        check("ram_data_2", ram_data_2, m_rd2);
        if (rd_pend) check("cpu_rdata", cpu_rdata, exp_q.pop_front());
        act = (fq.size() != 0) ? fq[0] : A_NONE;
        gnt = ((act == A_RD0) || (act == A_RD1)) && (!cpu_req || denied == MAX_WAIT);
        check("cpu_stall", cpu_stall, gnt && cpu_req);
        if (gnt) begin
            check("vga_mem_en", mem_en, 1'b1);
            check("vga_mem_we", mem_we, 1'b0);
            check("vga_mem_addr", mem_addr, FB_ADDR + ((act == A_RD1) ? 32'd4 : 32'd0));
        end else begin
            check("cpu_mem_en", mem_en, cpu_req);
            if (cpu_req) begin
                check("cpu_mem_addr", mem_addr, cpu_addr);
                check("cpu_mem_we", mem_we, cpu_we);
                if (cpu_we) check("cpu_mem_wdata", mem_wdata, cpu_wdata);
            end
        end
        m_stall = gnt && cpu_req;
        rd_pend = 1'b0;
        if (cpu_req && !m_stall) begin
            if (cpu_we) gold[cpu_addr[12:2]] = cpu_wdata;
            else begin
                exp_q.push_back(gold[cpu_addr[12:2]]);
                rd_pend = 1'b1;
            end
        end
        if (rst) begin
            fq.delete();
            m_rd1 = '0; m_rd2 = '0; m_miss = 1'b0; denied = 0;
            return;
        end
        was_len = fq.size();
        m_miss = frame_start && (was_len != 0);
        case (act)
            A_RD0, A_RD1: begin
                if (gnt) begin
                    snap[act] = gold[(FB_ADDR[12:2]) + 11'(act)];
                    void'(fq.pop_front());
                    denied = 0;
                end else if (denied < MAX_WAIT) denied++;
            end
            A_GAP: void'(fq.pop_front());
            A_COMMIT: begin
                void'(fq.pop_front());
                m_rd1 = snap[0];
                m_rd2 = snap[1];
            end
            default: ;
        endcase
        if (frame_start && was_len == 0) begin
            fq = '{A_RD0, A_GAP, A_RD1, A_GAP, A_COMMIT};
            denied = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic fs, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        frame_start = fs; cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic mid();
        @(negedge clk);
        model_step();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            mid();
            fin();
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] val);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        poke_en = 1'b1; poke_idx = addr[12:2]; poke_val = val;
        gold[addr[12:2]] = val;
        mid();
        fin();
        poke_en = 1'b0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        int          hold;       // cpu_req high in cycles 1..hold
        logic [31:0] w1;
        logic [31:0] w2;
        int          exp_vis;    // first cycle the new words are visible
        int          exp_stalls;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int stalls;
        logic [31:0] prev1, prev2;
        vecs[0] = '{0,  32'hDEAD_BEEF, 32'h1234_5678, 6,  0};
        vecs[1] = '{3,  32'h0000_0001, 32'h8000_0000, 9,  0};
        vecs[2] = '{15, 32'hFFFF_FFFF, 32'h0000_0000, 21, 0};
        vecs[3] = '{20, 32'hCAFE_F00D, 32'h0BAD_CAFE, 24, 1};
        vecs[4] = '{40, 32'h1357_9BDF, 32'h2468_ACE0, 36, 2};
        for (int i = 0; i < 2048; i++) gold[i] = init_val(i);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", fetch_busy, 1'b0);
        check("reset_rd1", ram_data_1, 32'h0);
        check("reset_rd2", ram_data_2, 32'h0);
        check("reset_miss", frame_miss, 1'b0);
        idle(2);

        prev1 = '0; prev2 = '0;
        foreach (vecs[v]) begin
            poke(FB_ADDR, vecs[v].w1);
            poke(FB_ADDR + 32'd4, vecs[v].w2);
            stalls = 0;
            for (int c = 0; c <= 40; c++) begin
                drive(c == 0, (c >= 1) && (c <= vecs[v].hold), 1'b0, 32'h40, 32'h0);
                mid();
                if (cpu_stall) stalls++;
                if (vecs[v].hold == 0 && c == 1) check("t1_addr_c1", mem_addr, 32'h1000);
                if (vecs[v].hold == 0 && c == 3) check("t1_addr_c3", mem_addr, 32'h1004);
                if (c == vecs[v].exp_vis - 1) begin
                    check("vec_old_rd1", ram_data_1, prev1);
                    check("vec_old_rd2", ram_data_2, prev2);
                end
                if (c == vecs[v].exp_vis) begin
                    check("vec_new_rd1", ram_data_1, vecs[v].w1);
                    check("vec_new_rd2", ram_data_2, vecs[v].w2);
                    check("vec_done", fetch_busy, 1'b0);
                end
                fin();
            end
            check("vec_stalls", 32'(stalls), 32'(vecs[v].exp_stalls));
            prev1 = vecs[v].w1; prev2 = vecs[v].w2;
            idle(2);
        end

        // CPU read of 0x20 in CAP1
        poke(32'h20, 32'h0BAD_F00D);
        poke(FB_ADDR, 32'h1111_1111);
        poke(FB_ADDR + 32'd4, 32'h2222_2222);
        for (int c = 0; c <= 7; c++) begin
            drive(c == 0, c == 2, 1'b0, 32'h20, 32'h0);
            mid();
            if (c == 2) check("cap1_addr", mem_addr, 32'h20);
            if (c == 3) check("cap1_rdata", cpu_rdata, 32'h0BAD_F00D);
            if (c == 6) check("cap1_rd1", ram_data_1, 32'h1111_1111);
            fin();
        end
        idle(2);

        // frame_start re-pulsed in RD2
        for (int c = 0; c <= 9; c++) begin
            drive((c == 0) || (c == 3), 1'b0, 1'b0, 32'h0, 32'h0);
            mid();
            if (c == 4) check("rd2_miss_on", frame_miss, 1'b1);
            if (c == 5) check("rd2_miss_off", frame_miss, 1'b0);
            if (c >= 6) check("rd2_single", fetch_busy, 1'b0);
            fin();
        end

        // CPU write to FB_ADDR+4 while RD1 waits
        for (int c = 0; c <= 8; c++) begin
            drive(c == 0, c == 1, 1'b1, FB_ADDR + 32'd4, 32'hAAAA_0000);
            mid();
            if (c == 1) check("wr_nostall", cpu_stall, 1'b0);
            if (c == 7) check("wr_rd2", ram_data_2, 32'hAAAA_0000);
            fin();
        end

        // frame_start in the COMMIT cycle
        for (int c = 0; c <= 8; c++) begin
            drive((c == 0) || (c == 5), 1'b0, 1'b0, 32'h0, 32'h0);
            mid();
            if (c == 6) check("commit_miss", frame_miss, 1'b1);
            if (c == 6 || c == 7) check("commit_idle", fetch_busy, 1'b0);
            fin();
        end

        // reset in CAP2
        for (int c = 0; c <= 7; c++) begin
            drive(c == 0, 1'b0, 1'b0, 32'h0, 32'h0);
            rst = (c == 4);
            mid();
            if (c == 5) begin
                check("rst_busy", fetch_busy, 1'b0);
                check("rst_rd1", ram_data_1, 32'h0);
                check("rst_rd2", ram_data_2, 32'h0);
                check("rst_miss", frame_miss, 1'b0);
            end
            fin();
        end
        rst = 1'b0;
        idle(2);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            if (!m_stall) begin
                case ($urandom_range(0, 3))
                    0:       a = FB_ADDR;
                    1:       a = FB_ADDR + 32'd4;
                    2:       a = 32'h20;
                    default: a = {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
                endcase
                drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6,
                      $urandom_range(0, 1) == 1, a, $urandom);
            end else begin
                frame_start = ($urandom_range(0, 15) == 0);
            end
            mid();
            fin();
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
